// File: rtl/cla_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional CLA_PIPE_FLAGS_EN adds the registered overflow and zero flags.
module cla_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NG = WIDTH / 4;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_pipe: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  // Handshake: each stage advances when its successor is empty or draining
  logic w_s2_adv;
  logic w_s1_adv;

  // Stage 1 combinational terms
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_c0;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_p;
  logic [WIDTH-1:0] r_s1_g;
  logic [NG-1:0]    r_s1_gp;
  logic [NG-1:0]    r_s1_gg;
  logic             r_s1_c0;

  // Stage 2 combinational terms
  logic [NG:0]      w_gc;
  logic             w_pp;
  logic             w_acc;
  logic [WIDTH-1:0] w_c;
  logic             w_rc;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  // Output stage registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_b  = in_sub ? ~in_b : in_b;
  assign w_c0 = in_sub ? 1'b1 : in_cin;
  assign w_p  = in_a ^ w_b;
  assign w_g  = in_a & w_b;

  // Group propagate/generate for each 4-bit slice
  always_comb begin : p_group_pg
    w_gp = '0;
    w_gg = '0;
    for (int k = 0; k < int'(NG); k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

  always_ff @(posedge clk) begin : p_s1_reg
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_g     <= '0;
      r_s1_gp    <= '0;
      r_s1_gg    <= '0;
      r_s1_c0    <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_p  <= w_p;
        r_s1_g  <= w_g;
        r_s1_gp <= w_gp;
        r_s1_gg <= w_gg;
        r_s1_c0 <= w_c0;
      end
    end
  end

  // Second-level lookahead: each group carry is a flat sum-of-products of G/P and c0
  always_comb begin : p_lookahead
    w_gc    = '0;
    w_gc[0] = r_s1_c0;
    w_pp    = 1'b1;
    w_acc   = 1'b0;
    for (int k = 0; k < int'(NG); k++) begin
      w_pp  = 1'b1;
      w_acc = 1'b0;
      for (int j = k; j >= 0; j--) begin
        w_acc = w_acc | (w_pp & r_s1_gg[j]);
        w_pp  = w_pp & r_s1_gp[j];
      end
      w_gc[k+1] = w_acc | (w_pp & r_s1_c0);
    end
  end

  // In-group carries start from the resolved group carry-in
  always_comb begin : p_bit_carry
    w_c  = '0;
    w_rc = 1'b0;
    for (int k = 0; k < int'(NG); k++) begin
      w_rc = w_gc[k];
      for (int i = 0; i < 4; i++) begin
        w_c[4*k+i] = w_rc;
        w_rc = r_s1_g[4*k+i] | (r_s1_p[4*k+i] & w_rc);
      end
    end
  end

  assign w_sum  = r_s1_p ^ w_c;
  assign w_cout = w_gc[NG];

  always_ff @(posedge clk) begin : p_s2_reg
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;

`ifdef CLA_PIPE_FLAGS_EN
  logic r_s1_a_msb;
  logic r_s1_b_msb;
  logic w_ovf;
  logic w_zero;
  logic r_ovf;
  logic r_zero;

  // Sign bits of A and the (possibly inverted) B feed the overflow test
  always_ff @(posedge clk) begin : p_s1_sign
    if (rst) begin
      r_s1_a_msb <= 1'b0;
      r_s1_b_msb <= 1'b0;
    end else if (w_s1_adv && in_valid) begin
      r_s1_a_msb <= in_a[WIDTH-1];
      r_s1_b_msb <= w_b[WIDTH-1];
    end
  end

  assign w_ovf  = (r_s1_a_msb == r_s1_b_msb) && (w_sum[WIDTH-1] != r_s1_a_msb);
  assign w_zero = ~|w_sum;

  always_ff @(posedge clk) begin : p_s2_flags
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign out_ovf  = r_ovf;
  assign out_zero = r_zero;
`else
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

endmodule
